// File: rtl/my_stream_pkg.sv
// Shared types and helpers for the two-channel stream merger.
// The source enum doubles as the output tag a downstream demux selects on.
package my_stream_pkg;

   typedef enum logic {
      SRC_A = 1'b0,
      SRC_B = 1'b1
   } src_e;

   localparam int DEFAULT_WIDTH = 8;

   // Round-robin pick; the result is only meaningful when a_v or b_v is set.
   function automatic src_e rr_grant(input logic a_v, input logic b_v, input src_e last);
      src_e pick;
      pick = SRC_A;
      if (a_v && b_v) begin
         if (last == SRC_A) pick = SRC_B;
         else               pick = SRC_A;
      end else if (b_v) begin
         pick = SRC_B;
      end
      return pick;
   endfunction

endpackage

// File: rtl/my_mux.sv
// Plain WIDTH-bit 2:1 multiplexer; sel=0 passes a_i, sel=1 passes b_i.
// Inverse of the routing demux, so the tag it consumes is the tag the demux needs.
module my_mux
   import my_stream_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             sel_i,
   output logic [WIDTH-1:0] out_o
);

   assign out_o = sel_i ? b_i : a_i;

endmodule

// File: rtl/my_stream_mux.sv
// Round-robin merge of two valid/ready channels into one registered output
// stage tagged with its source; sustains one beat per cycle.
module my_stream_mux
   import my_stream_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a_in,
   input  logic             a_valid,
   output logic             a_ready,
   input  logic [WIDTH-1:0] b_in,
   input  logic             b_valid,
   output logic             b_ready,
   output logic [WIDTH-1:0] out,
   output logic             out_sel,
   output logic             out_valid,
   input  logic             out_ready
);

   src_e             grant;
   src_e             last_grant_q, last_grant_d;
   src_e             out_sel_q, out_sel_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic [WIDTH-1:0] mux_data;
   logic             out_valid_q, out_valid_d;
   logic             any_valid;
   logic             can_accept;
   logic             accept;

   assign any_valid = a_valid | b_valid;
   assign grant     = rr_grant(a_valid, b_valid, last_grant_q);

   // Ready is held low while reset is asserted so nothing is handshaken into a stage being cleared.
   assign can_accept = rst_n && (!out_valid_q || out_ready);
   assign accept     = can_accept && any_valid;
   assign a_ready    = accept && (grant == SRC_A);
   assign b_ready    = accept && (grant == SRC_B);

   my_mux #(.WIDTH(WIDTH)) u_mux (
      .a_i   (a_in),
      .b_i   (b_in),
      .sel_i (grant),
      .out_o (mux_data)
   );

   always_comb begin
      out_d        = out_q;
      out_sel_d    = out_sel_q;
      out_valid_d  = out_valid_q;
      last_grant_d = last_grant_q;
      if (accept) begin
         out_d        = mux_data;
         out_sel_d    = grant;
         out_valid_d  = 1'b1;
         last_grant_d = grant;
      end else if (out_ready) begin
         out_valid_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q        <= '0;
         out_sel_q    <= SRC_A;
         out_valid_q  <= 1'b0;
         last_grant_q <= SRC_B;
      end else begin
         out_q        <= out_d;
         out_sel_q    <= out_sel_d;
         out_valid_q  <= out_valid_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign out       = out_q;
   assign out_sel   = out_sel_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_my_stream_mux.sv
// Bench for my_stream_mux: directed scenarios plus a randomized run scored
// against a cycle-level model of the merge rules.
module tb_my_stream_mux;

   logic       clk;
   logic       rst_n;
   logic [7:0] a_in, b_in;
   logic       a_valid, b_valid;
   logic       a_ready, b_ready;
   logic [7:0] out_w;
   logic       out_sel;
   logic       out_valid;
   logic       out_ready;

   int checks = 0;
   int errors = 0;

   my_stream_mux #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a_in      (a_in),
      .a_valid   (a_valid),
      .a_ready   (a_ready),
      .b_in      (b_in),
      .b_valid   (b_valid),
      .b_ready   (b_ready),
      .out       (out_w),
      .out_sel   (out_sel),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle_inputs();
      a_valid = 1'b0;
      b_valid = 1'b0;
      a_in    = 8'h00;
      b_in    = 8'h00;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      idle_inputs();
      out_ready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      a_valid   = 1'b1;
      a_in      = 8'h3C;
      b_valid   = 1'b0;
      b_in      = 8'h00;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      checks++;
      if (a_ready !== 1'b0) begin errors++; $display("FAIL reset_a_ready got %b want 0", a_ready); end
      checks++;
      if (out_w !== 8'h00 || out_sel !== 1'b0) begin
         errors++; $display("FAIL reset_out got %h/%b want 00/0", out_w, out_sel);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (a_ready !== 1'b1) begin errors++; $display("FAIL first_a_ready got %b want 1", a_ready); end
      @(posedge clk); #1;
      checks++;
      if (out_w !== 8'h3C || out_sel !== 1'b0 || out_valid !== 1'b1) begin
         errors++; $display("FAIL first_beat got %h/%b/%b want 3c/0/1", out_w, out_sel, out_valid);
      end
   endtask

   task automatic test_single_b();
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         a_valid   = 1'b0;
         b_valid   = 1'b1;
         b_in      = 8'(i);
         out_ready = 1'b1;
         @(posedge clk); #1;
         checks++;
         if (out_w !== 8'(i) || out_sel !== 1'b1 || out_valid !== 1'b1) begin
            errors++; $display("FAIL single_b[%0d] got %h/%b/%b want %h/1/1", i, out_w, out_sel, out_valid, 8'(i));
         end
      end
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic test_contention();
      logic [7:0] exp_d [4];
      logic       exp_s [4];
      exp_d = '{8'hAA, 8'hBB, 8'hAA, 8'hBB};
      exp_s = '{1'b0, 1'b1, 1'b0, 1'b1};
      do_reset();
      a_valid = 1'b1; a_in = 8'hAA;
      b_valid = 1'b1; b_in = 8'hBB;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         checks++;
         if (out_w !== exp_d[i] || out_sel !== exp_s[i] || out_valid !== 1'b1) begin
            errors++; $display("FAIL contention[%0d] got %h/%b/%b want %h/%b/1", i, out_w, out_sel, out_valid, exp_d[i], exp_s[i]);
         end
      end
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      a_valid = 1'b1; a_in = 8'h55; out_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (out_w !== 8'h55 || out_valid !== 1'b1) begin
         errors++; $display("FAIL bp_load got %h/%b want 55/1", out_w, out_valid);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         out_ready = 1'b0; a_valid = 1'b1; a_in = 8'h66;
         #1;
         checks++;
         if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
            errors++; $display("FAIL bp_ready[%0d] got %b%b want 00", i, a_ready, b_ready);
         end
         @(posedge clk); #1;
         checks++;
         if (out_w !== 8'h55 || out_sel !== 1'b0 || out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_hold[%0d] got %h/%b/%b want 55/0/1", i, out_w, out_sel, out_valid);
         end
      end
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      checks++;
      if (a_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b want 1", a_ready); end
      @(posedge clk); #1;
      checks++;
      if (out_w !== 8'h66 || out_valid !== 1'b1) begin
         errors++; $display("FAIL bp_next got %h/%b want 66/1", out_w, out_valid);
      end
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic test_drain_refill();
      @(negedge clk);
      a_valid = 1'b1; a_in = 8'h44; out_ready = 1'b1;
      @(negedge clk);
      a_valid = 1'b0; b_valid = 1'b1; b_in = 8'h77;
      #1;
      checks++;
      if (out_valid !== 1'b1 || b_ready !== 1'b1) begin
         errors++; $display("FAIL refill_ready got valid=%b b_ready=%b want 1/1", out_valid, b_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (out_w !== 8'h77 || out_sel !== 1'b1 || out_valid !== 1'b1) begin
         errors++; $display("FAIL refill_beat got %h/%b/%b want 77/1/1", out_w, out_sel, out_valid);
      end
      @(negedge clk);
      idle_inputs();
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL drain got %b want 0", out_valid); end
   endtask

   task automatic test_reset_midstream();
      @(negedge clk);
      a_valid = 1'b1; a_in = 8'h12; out_ready = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_load got %b want 1", out_valid); end
      @(negedge clk);
      idle_inputs();
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_async_clear got %b want 0", out_valid); end
      @(negedge clk);
      rst_n = 1'b1; out_ready = 1'b1;
      a_valid = 1'b1; a_in = 8'hAA;
      b_valid = 1'b1; b_in = 8'hBB;
      @(posedge clk); #1;
      checks++;
      if (out_w !== 8'hAA || out_sel !== 1'b0 || out_valid !== 1'b1) begin
         errors++; $display("FAIL mid_first_grant got %h/%b/%b want aa/0/1", out_w, out_sel, out_valid);
      end
      @(negedge clk);
      idle_inputs();
   endtask

   // Model: one output slot plus a "whose turn on a tie" flag.
   task automatic test_random();
      logic       m_valid;
      logic [7:0] m_data;
      logic       m_src;
      logic       m_turn_b;
      logic       room, take_a, take_b;
      do_reset();
      m_valid  = 1'b0;
      m_data   = 8'h00;
      m_src    = 1'b0;
      m_turn_b = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge clk);
         a_valid   = ($urandom_range(0, 3) != 0);
         b_valid   = ($urandom_range(0, 3) != 0);
         a_in      = 8'($urandom);
         b_in      = 8'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         room   = !m_valid || out_ready;
         take_a = room && a_valid && (!b_valid || !m_turn_b);
         take_b = room && b_valid && (!a_valid || m_turn_b);
         #1;
         checks++;
         if (a_ready !== take_a || b_ready !== take_b) begin
            errors++; $display("FAIL rand_ready cyc %0d got %b%b want %b%b", cyc, a_ready, b_ready, take_a, take_b);
         end
         @(posedge clk);
         if (take_a) begin
            m_valid = 1'b1; m_data = a_in; m_src = 1'b0; m_turn_b = 1'b1;
         end else if (take_b) begin
            m_valid = 1'b1; m_data = b_in; m_src = 1'b1; m_turn_b = 1'b0;
         end else if (out_ready) begin
            m_valid = 1'b0;
         end
         #1;
         checks++;
         if (out_valid !== m_valid || (m_valid && (out_w !== m_data || out_sel !== m_src))) begin
            errors++; $display("FAIL rand_out cyc %0d got %b/%h/%b want %b/%h/%b", cyc, out_valid, out_w, out_sel, m_valid, m_data, m_src);
         end
      end
      @(negedge clk);
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_single_b();
      test_contention();
      test_backpressure();
      test_drain_refill();
      test_reset_midstream();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/my_stream_mux.md
Name: my_stream_mux

Overview:
- Sequential 2-to-1 stream merger: the gathering counterpart of the demultiplexer. Two valid/ready input channels (A, B) are arbitrated round-robin onto one registered output channel.
- Each output beat carries a source tag (out_sel) equal to the select value a downstream demux needs to route it back.
- Sits between two producers and a shared consumer. One output register stage; sustains one beat per cycle.

Parameters:
- WIDTH, 8, data width of each channel.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- a_in  input  WIDTH  channel A data.
- a_valid  input  1  channel A data valid.
- a_ready  output  1  channel A beat accepted this cycle when a_valid && a_ready.
- b_in  input  WIDTH  channel B data.
- b_valid  input  1  channel B data valid.
- b_ready  output  1  channel B beat accepted this cycle when b_valid && b_ready.
- out  output  WIDTH  merged data, registered.
- out_sel  output  1  source tag: 0 = A, 1 = B, registered.
- out_valid  output  1  out/out_sel hold a beat.
- out_ready  input  1  consumer accepts a beat when out_valid && out_ready.

Behaviour:
- Interface: one clock, clk; reset rst_n, asynchronous, active-low.
- Reset state: out_valid=0, out=0, out_sel=0, last_grant=1. The first contended grant goes to A.
- can_accept = !out_valid || out_ready. The register drains and refills in the same cycle.
- Grant (combinational):
  - Only a_valid: A.
  - Only b_valid: B.
  - Both valid: the source != last_grant.
  - Neither valid: none.
- a_ready = can_accept && grant==A. b_ready = can_accept && grant==B. Never both 1.
- Ready depends combinationally on a_valid, b_valid and out_ready. It does not depend on data.
- On an accept edge:
  - out <= selected data.
  - out_sel <= granted source.
  - out_valid <= 1.
  - last_grant <= granted source.
- On a drain without accept: out_valid <= 0. out and out_sel keep their values; their contents are don't-care.
- Latency: 1 cycle from input handshake to out_valid.
- Throughput: 1 beat/cycle while out_ready=1.
- Stall: while out_valid && !out_ready, out and out_sel are stable, and a_ready=b_ready=0.
- last_grant updates only on an actual accept. A single-source run does not alter fairness toward the next contention.
- Under continuous contention, grants alternate A,B,A,B...
- Inputs need not hold valid when not accepted. The block never drops or duplicates an accepted beat.
- Reset asserted mid-transfer: out_valid clears immediately (asynchronously). A buffered beat is discarded. last_grant returns to 1.
- No X-propagation: with neither input valid, out and out_sel are unchanged.

Decomposition:
- Package my_stream_pkg:
  - typedef enum logic {SRC_A=1'b0, SRC_B=1'b1} src_e, used for out_sel and last_grant.
  - localparam DEFAULT_WIDTH=8.
- Sub-module my_mux: combinational WIDTH-bit 2:1 mux (a, b, sel -> out), instantiated for the data path. It is the direct inverse of the existing demux and is reusable by the bench as a reference model.
- Arbiter and output register stay in my_stream_mux.

Test Plan:
- Reset: hold rst_n=0 with a_valid=1 -> out_valid=0, a_ready=0. Release rst_n. a_in=8'h3C, out_ready=1 -> next cycle out=8'h3C, out_sel=0, out_valid=1.
- Single source B: b_valid=1 with b_in=8'h01,8'h02,8'h03 on consecutive cycles, out_ready=1 -> out=01,02,03 on consecutive cycles, out_sel=1, no bubbles.
- Contention after reset: a_valid=b_valid=1, a_in=8'hAA, b_in=8'hBB held for 4 cycles, out_ready=1 -> out sequence AA,BB,AA,BB; out_sel 0,1,0,1.
- Backpressure: out holds 8'h55, out_ready=0 for 3 cycles with a_valid=1 -> out stays 8'h55, a_ready=0 throughout. Raise out_ready -> a_ready=1 same cycle; next beat appears the following cycle.
- Drain-and-refill: out_valid=1, out_ready=1, b_valid=1, b_in=8'h77 -> b_ready=1 that cycle; next cycle out=8'h77, out_valid=1.
- Reset mid-stream: assert rst_n=0 while out_valid=1 -> out_valid=0 before the next clock edge. After release, contention grants A first.
